a2d_sequencer: RTL and testbench
================================

A2D_SEQUENCER -- requirements
Module: a2d_sequencer

Interface
REQ-001 SHALL have parameter FAST_SIM, default 1, selecting a short inter-conversion interval for simulation when nonzero.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port wrt  output  1  one-cycle strobe starting an SPI transaction.
REQ-005 SHALL have port cmd  output  16  SPI command word, valid whenever wrt is high.
REQ-006 SHALL have port done  input  1  SPI master transaction-complete pulse.
REQ-007 SHALL have port rd_data  input  16  SPI receive word, valid in the cycle done is high.
REQ-008 SHALL have ports batt, curr, brake, torque  output  12 each  latest conversion results.

Function
REQ-009 SHALL convert the channels round-robin in the order batt (ADC ch 0), curr (ch 1), brake (ch 3), torque (ch 4), then wrap to batt.
REQ-010 SHALL implement the states IDLE, CMD1, WAIT1, CMD2, WAIT2.
REQ-011 In IDLE, SHALL increment a 14-bit interval timer every cycle.
REQ-012 SHALL leave IDLE for CMD1 when the timer is all-ones: 16383 when FAST_SIM=0, or timer[8:0]=511 when FAST_SIM!=0.
REQ-013 SHALL clear the timer to 0 on every exit from IDLE.
REQ-014 In CMD1, SHALL assert wrt for exactly one cycle with cmd = {2'b00, ch[2:0], 11'h000}, then enter WAIT1.
REQ-015 In WAIT1, SHALL wait for done=1, then enter CMD2; rd_data is discarded.
REQ-016 In CMD2, SHALL assert wrt for one cycle with the same cmd, then enter WAIT2.
REQ-017 In WAIT2, on done=1, SHALL load rd_data[11:0] into the current channel's result register, advance the channel pointer, and return to IDLE.
REQ-018 A result register SHALL update on the cycle after the done cycle and hold its value until the next conversion of that channel.
REQ-019 SHALL ignore done in IDLE, CMD1 and CMD2; done sampled the same cycle wrt is high SHALL have no effect.
REQ-020 The channel pointer SHALL be 2 bits (0..3) and wrap from 3 to 0; the mapping 0->ch0, 1->ch1, 2->ch3, 3->ch4 SHALL be combinational.
REQ-021 wrt SHALL be low in every state except CMD1 and CMD2.
REQ-022 cmd SHALL be 16'h0000 outside CMD1 and CMD2.
REQ-023 There SHALL be no timeout in WAIT1 or WAIT2; the block waits for done indefinitely.

Reset
REQ-024 While rst is high, SHALL force: state IDLE, timer 0, channel pointer 0, wrt 0, cmd 0, and batt, curr, brake, torque all 12'h000.
REQ-025 Assertion of rst in mid-transaction (any state) SHALL abandon the transaction without updating any result register.
REQ-026 The first wrt after rst deasserts SHALL occur after the full interval timeout and SHALL target batt (ch 0).

Configuration
REQ-027 When macro A2D_VALID_EN is defined, SHALL add output vld (1 bit), reset to 0.
REQ-028 With A2D_VALID_EN defined, vld SHALL set on the cycle after the first torque capture following reset and stay set until reset.
REQ-029 Without A2D_VALID_EN, port vld and its logic SHALL be absent, with no other behavioural change.

Verification
REQ-030 Reset, FAST_SIM=1, SPI model answering done 40 cycles after wrt -> first wrt exactly 512 cycles after rst release; cmd=16'h0000; 2 wrt pulses per conversion.
REQ-031 Model returns 12'hA98, 12'h123, 12'h456, 12'h789 on successive second transactions -> batt, curr, brake, torque equal these values in order; the 5th conversion has cmd=16'h0000 and updates batt only.
REQ-032 During the first conversion, check cmd across the four channels -> observed sequence 16'h0000, 16'h0800, 16'h1800, 16'h2000.
REQ-033 rst pulsed while in WAIT2 for curr, with rd_data=16'h0FFF -> curr remains 0; next conversion targets batt after a fresh 512-cycle interval.
REQ-034 Spurious done pulses in IDLE, and done coincident with wrt -> no state advance and no register update; done 1 cycle after wrt -> accepted.
REQ-035 A2D_VALID_EN defined -> vld=0 through the first three captures; vld=1 the cycle after the torque capture; vld=0 again after rst.

Source files
------------

// File: rtl/a2d_sequencer.sv
// a2d_sequencer: round-robin SPI ADC sequencer for batt/curr/brake/torque (ADC ch 0,1,3,4).
// Optional macro A2D_VALID_EN adds a sticky vld output once the first torque result lands.
module a2d_sequencer #(
  parameter int FAST_SIM = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] brake,
  output logic [11:0] torque
`ifdef A2D_VALID_EN
  ,
  output logic        vld
`endif
);

  typedef enum logic [2:0] {IDLE, CMD1, WAIT1, CMD2, WAIT2} state_t;

  state_t      state_q, state_d;
  logic [13:0] timer_q, timer_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [11:0] batt_q, curr_q, brake_q, torque_q;
  logic        capture;
  logic        timeout;
  logic [2:0]  adc_ch;
  logic [15:0] cmd_w;
  logic        unused_rd;

  // Only the low 12 bits of the SPI word carry the conversion result.
  assign unused_rd = ^rd_data[15:12];

  assign timeout = (FAST_SIM != 0) ? (&timer_q[8:0]) : (&timer_q);

  always_comb begin
    case (ptr_q)
      2'd0:    adc_ch = 3'd0;
      2'd1:    adc_ch = 3'd1;
      2'd2:    adc_ch = 3'd3;
      default: adc_ch = 3'd4;
    endcase
  end

  assign cmd_w = {2'b00, adc_ch, 11'h000};

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    ptr_d   = ptr_q;
    wrt     = 1'b0;
    cmd     = 16'h0000;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (timeout) begin
          state_d = CMD1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 14'd1;
        end
      end
      CMD1: begin
        wrt     = 1'b1;
        cmd     = cmd_w;
        state_d = WAIT1;
      end
      WAIT1: begin
        if (done) state_d = CMD2;
      end
      CMD2: begin
        wrt     = 1'b1;
        cmd     = cmd_w;
        state_d = WAIT2;
      end
      WAIT2: begin
        if (done) begin
          capture = 1'b1;
          ptr_d   = ptr_q + 2'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      batt_q   <= '0;
      curr_q   <= '0;
      brake_q  <= '0;
      torque_q <= '0;
    end else if (capture) begin
      case (ptr_q)
        2'd0:    batt_q   <= rd_data[11:0];
        2'd1:    curr_q   <= rd_data[11:0];
        2'd2:    brake_q  <= rd_data[11:0];
        default: torque_q <= rd_data[11:0];
      endcase
    end
  end

  assign batt   = batt_q;
  assign curr   = curr_q;
  assign brake  = brake_q;
  assign torque = torque_q;

`ifdef A2D_VALID_EN
  logic vld_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
    end else if (capture && (ptr_q == 2'd3)) begin
      vld_q <= 1'b1;
    end
  end

  assign vld = vld_q;
`endif

endmodule

// File: tb/tb_a2d_sequencer.sv
// Bench for a2d_sequencer: SPI slave model with programmable done latency and an
// expected-result model tracking channel rotation, result registers and vld.
module tb_a2d_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;
  logic [11:0] batt, curr, brake, torque;
`ifdef A2D_VALID_EN
  logic        vld;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int wrt_cnt = 0;

  logic [11:0] exp_res [4];
  int          exp_ptr;
  logic        exp_vld;
  int          ch_map [4];

  typedef struct {
    logic [15:0] junk;
    logic [15:0] val;
    logic [15:0] exp_cmd;
  } vec_t;

  vec_t tbl [5];

  always #5 clk = ~clk;

  a2d_sequencer #(.FAST_SIM(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .wrt     (wrt),
    .cmd     (cmd),
    .done    (done),
    .rd_data (rd_data),
    .batt    (batt),
    .curr    (curr),
    .brake   (brake),
    .torque  (torque)
`ifdef A2D_VALID_EN
    ,
    .vld     (vld)
`endif
  );

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (wrt) wrt_cnt++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) exp_res[i] = 12'h000;
    exp_ptr = 0;
    exp_vld = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".batt"},   32'(batt),   32'(exp_res[0]));
    check({tag, ".curr"},   32'(curr),   32'(exp_res[1]));
    check({tag, ".brake"},  32'(brake),  32'(exp_res[2]));
    check({tag, ".torque"}, 32'(torque), 32'(exp_res[3]));
`ifdef A2D_VALID_EN
    check({tag, ".vld"},    32'(vld),    32'(exp_vld));
`endif
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".wrt"}, 32'(wrt), 32'd0);
    check({tag, ".cmd"}, 32'(cmd), 32'd0);
    check({tag, ".batt"},   32'(batt),   32'd0);
    check({tag, ".curr"},   32'(curr),   32'd0);
    check({tag, ".brake"},  32'(brake),  32'd0);
    check({tag, ".torque"}, 32'(torque), 32'd0);
`ifdef A2D_VALID_EN
    check({tag, ".vld"},    32'(vld),    32'd0);
`endif
  endtask

  // Counts edges until wrt is seen; optional spurious done pulses while idle.
  task automatic wait_wrt(input bit spur, output int n);
    n = 0;
    do begin
      step();
      n++;
      if (!wrt && spur) begin
        done    = ($urandom_range(0, 5) == 0);
        rd_data = 16'($urandom);
      end
    end while (!wrt && n < 2000);
    if (!wrt) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wrt_timeout: got no wrt after %0d cycles, required one at 512", n);
    end
  endtask

  // One full conversion: two SPI transactions answered lat1/lat2 cycles after each wrt.
  task automatic do_conv(input logic [15:0] junk, input logic [15:0] val,
                         input logic [15:0] exp_cmd, input bit spur, input bit coinc,
                         input int lat1, input int lat2);
    int n;
    int p0;
    p0 = wrt_cnt;
    wait_wrt(spur, n);
    check("interval", 32'(n), 32'd512);
    check("cmd1", 32'(cmd), 32'(exp_cmd));
    check_regs("idle");
    done = coinc; rd_data = 16'hFFFF;
    step();
    done = 1'b0;
    check("wrt_one_cycle", 32'(wrt), 32'd0);
    repeat (lat1 - 1) step();
    done = 1'b1; rd_data = junk;
    step();
    done = 1'b0;
    check("wrt2", 32'(wrt), 32'd1);
    check("cmd2", 32'(cmd), 32'(exp_cmd));
    check_regs("after_tx1");
    done = coinc; rd_data = 16'hFFFF;
    step();
    done = 1'b0;
    repeat (lat2 - 1) step();
    done = 1'b1; rd_data = val;
    step();
    done = 1'b0; rd_data = 16'($urandom);
    exp_res[exp_ptr] = val[11:0];
    if (exp_ptr == 3) exp_vld = 1'b1;
    exp_ptr = (exp_ptr + 1) % 4;
    check_regs("capture");
    check("wrt_pulses", 32'(wrt_cnt - p0), 32'd2);
  endtask

  initial begin
    int n;
    ch_map = '{0, 1, 3, 4};
    tbl[0] = '{junk: 16'h5A5A, val: 16'h0A98, exp_cmd: 16'h0000};
    tbl[1] = '{junk: 16'hFFFF, val: 16'h0123, exp_cmd: 16'h0800};
    tbl[2] = '{junk: 16'h0F0F, val: 16'hF456, exp_cmd: 16'h1800};
    tbl[3] = '{junk: 16'h1234, val: 16'h0789, exp_cmd: 16'h2000};
    tbl[4] = '{junk: 16'h0ABC, val: 16'h0BCD, exp_cmd: 16'h0000};

    rst = 1'b1; done = 1'b0; rd_data = 16'h0000;
    model_reset();
    repeat (3) step();
    check_reset("rst_init");
    rst = 1'b0;

    for (int i = 0; i < 5; i++)
      do_conv(tbl[i].junk, tbl[i].val, tbl[i].exp_cmd, 1'b0, 1'b0, 40, 40);

    // Reset while waiting for the curr result: nothing may be captured.
    wait_wrt(1'b0, n);
    check("rst_test.interval", 32'(n), 32'd512);
    check("rst_test.cmd", 32'(cmd), 32'h0800);
    step();
    repeat (39) step();
    done = 1'b1; rd_data = 16'h0555;
    step();
    done = 1'b0;
    check("rst_test.wrt2", 32'(wrt), 32'd1);
    step();
    rd_data = 16'h0FFF;
    repeat (10) step();
    done = 1'b1;
    #2 rst = 1'b1;
    #1 check_reset("rst_mid");
    step();
    step();
    done = 1'b0;
    rst = 1'b0;
    model_reset();
    check_regs("rst_after");
    do_conv(16'h0AAA, 16'h0321, 16'h0000, 1'b0, 1'b0, 40, 40);

    // Spurious done while idle, done coincident with wrt, and done one cycle after wrt.
    do_conv(16'h0777, 16'h0E1F, 16'h0800, 1'b1, 1'b1, 1, 1);

    for (int i = 0; i < 8; i++)
      do_conv(16'($urandom), 16'($urandom), 16'(ch_map[exp_ptr] << 11),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(1, 60)), int'($urandom_range(1, 60)));

    rst = 1'b1;
    step();
    check_reset("rst_final");
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
